// File: rtl/batrider_pcm_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | batrider_pcm_arbiter_pkg                                             |
// | PCM address/data widths and arbiter state encoding for the sound top |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package batrider_pcm_arbiter_pkg;

  localparam int PCM_AW = 21;
  localparam int PCM_DW = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_WAIT   = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/batrider_pcm_arbiter_slot.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | batrider_pcm_arbiter_slot                                            |
// | One-entry byte cache (valid/tag/data) with live hit compare          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module batrider_pcm_arbiter_slot
  import batrider_pcm_arbiter_pkg::*;
#(
  parameter int AW = PCM_AW,
  parameter int DW = PCM_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr_i,
  input  logic          fill_i,
  input  logic [AW-1:0] fill_tag_i,
  input  logic [DW-1:0] fill_data_i,
  output logic          hit_o,
  output logic [DW-1:0] data_o
);

  logic          valid_q;
  logic [AW-1:0] tag_q;
  logic [DW-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (fill_i) begin
      valid_q <= 1'b1;
      tag_q   <= fill_tag_i;
      data_q  <= fill_data_i;
    end
  end

  assign hit_o  = valid_q && (tag_q == addr_i);
  assign data_o = data_q;

endmodule
`default_nettype wire

// File: rtl/batrider_pcm_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | batrider_pcm_arbiter                                                 |
// | Round-robin sharing of one SDRAM PCM port between two OKI6295 caches |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module batrider_pcm_arbiter
  import batrider_pcm_arbiter_pkg::*;
#(
  parameter int AW    = PCM_AW,
  parameter int DW    = PCM_DW,
  parameter int OKDLY = 1
) (
  input  logic          CLK96,
  input  logic          RESET96_N,
  input  logic [AW-1:0] REQ0_ADDR,
  output logic [DW-1:0] REQ0_DATA,
  output logic          REQ0_OK,
  input  logic [AW-1:0] REQ1_ADDR,
  output logic [DW-1:0] REQ1_DATA,
  output logic          REQ1_OK,
  output logic          ROM_CS,
  output logic [AW-1:0] ROM_ADDR,
  input  logic [DW-1:0] ROM_DOUT,
  input  logic          ROM_OK,
  output logic          BUSY
);

  localparam logic [2:0] c_okdly = 3'(OKDLY);

  state_e        state_q, state_d;
  logic          rom_cs_q, rom_cs_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic [AW-1:0] tag_pend_q, tag_pend_d;
  logic          last_grant_q, last_grant_d;
  logic [2:0]    cnt_q, cnt_d;

  logic [1:0]    hit;
  logic [1:0]    miss;
  logic [1:0]    fill;
  logic          grant;
  logic [AW-1:0] req_addr  [2];
  logic [DW-1:0] slot_data [2];

  assign req_addr[0] = REQ0_ADDR;
  assign req_addr[1] = REQ1_ADDR;

  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    batrider_pcm_arbiter_slot #(
      .AW(AW),
      .DW(DW)
    ) u_slot (
      .clk        (CLK96),
      .rst_n      (RESET96_N),
      .addr_i     (req_addr[gi]),
      .fill_i     (fill[gi]),
      .fill_tag_i (tag_pend_q),
      .fill_data_i(ROM_DOUT),
      .hit_o      (hit[gi]),
      .data_o     (slot_data[gi])
    );
  end

  assign miss = ~hit;

  always_comb begin
    state_d      = state_q;
    rom_cs_d     = rom_cs_q;
    rom_addr_d   = rom_addr_q;
    tag_pend_d   = tag_pend_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    fill         = 2'b00;
    grant        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|miss) begin
          // Tie goes to whoever did not win last time.
          grant        = (miss == 2'b11) ? ~last_grant_q : miss[1];
          rom_cs_d     = 1'b1;
          rom_addr_d   = req_addr[grant];
          tag_pend_d   = req_addr[grant];
          last_grant_d = grant;
          cnt_d        = c_okdly;
          state_d      = (OKDLY > 0) ? ST_SETTLE : ST_WAIT;
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ROM_OK) begin
          fill[last_grant_q] = 1'b1;
          rom_cs_d           = 1'b0;
          state_d            = ST_IDLE;
        end
      end
      default: begin
        rom_cs_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK96 or negedge RESET96_N) begin
    if (!RESET96_N) begin
      state_q      <= ST_IDLE;
      rom_cs_q     <= 1'b0;
      rom_addr_q   <= '0;
      tag_pend_q   <= '0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      rom_cs_q     <= rom_cs_d;
      rom_addr_q   <= rom_addr_d;
      tag_pend_q   <= tag_pend_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  assign REQ0_OK   = hit[0];
  assign REQ1_OK   = hit[1];
  assign REQ0_DATA = slot_data[0];
  assign REQ1_DATA = slot_data[1];
  assign ROM_CS    = rom_cs_q;
  assign ROM_ADDR  = rom_addr_q;
  assign BUSY      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_batrider_pcm_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_batrider_pcm_arbiter                                              |
// | Vector table, corner sequences and random streams against a ROM model|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_batrider_pcm_arbiter;

  localparam int AW = 21;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, ok0, ok1, cs, busy, rok;
  logic [AW-1:0] a0, a1, raddr;
  logic [DW-1:0] d0, d1, rdout;

  logic          rst2_n, k0, k1, cs2, busy2, rok2;
  logic [AW-1:0] b0, b1, raddr2, lag_addr;
  logic [DW-1:0] e0, e1, rdout2;

  logic          ok_ovr, ok_force, fix_en, rand_dly;
  logic [DW-1:0] fix_val;
  logic [3:0]    fixed_dly, resp_cnt;
  logic          resp_active;

  int checks = 0;
  int errors = 0;

  batrider_pcm_arbiter #(.AW(AW), .DW(DW), .OKDLY(1)) u_dut (
    .CLK96(clk), .RESET96_N(rst_n),
    .REQ0_ADDR(a0), .REQ0_DATA(d0), .REQ0_OK(ok0),
    .REQ1_ADDR(a1), .REQ1_DATA(d1), .REQ1_OK(ok1),
    .ROM_CS(cs), .ROM_ADDR(raddr), .ROM_DOUT(rdout), .ROM_OK(rok), .BUSY(busy)
  );

  batrider_pcm_arbiter #(.AW(AW), .DW(DW), .OKDLY(2)) u_dut2 (
    .CLK96(clk), .RESET96_N(rst2_n),
    .REQ0_ADDR(b0), .REQ0_DATA(e0), .REQ0_OK(k0),
    .REQ1_ADDR(b1), .REQ1_DATA(e1), .REQ1_OK(k1),
    .ROM_CS(cs2), .ROM_ADDR(raddr2), .ROM_DOUT(rdout2), .ROM_OK(rok2), .BUSY(busy2)
  );

  function automatic logic [7:0] rom_byte(input logic [AW-1:0] a);
    logic [AW-1:0] x;
    x = a ^ (a >> 7) ^ (a >> 14);
    return x[7:0] ^ 8'hA5;
  endfunction

  // SDRAM stand-in: ROM_OK rises a chosen number of cycles after a request is seen.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_active <= 1'b0;
      resp_cnt    <= 4'd0;
    end else if (!cs) begin
      resp_active <= 1'b0;
    end else if (!resp_active) begin
      resp_active <= 1'b1;
      resp_cnt    <= rand_dly ? 4'($urandom_range(0, 10)) : fixed_dly;
    end else if (resp_cnt != 4'd0) begin
      resp_cnt <= resp_cnt - 4'd1;
    end
  end

  assign rok   = ok_ovr ? ok_force : (cs && resp_active && (resp_cnt == 4'd0));
  assign rdout = fix_en ? fix_val : rom_byte(raddr);

  // Second port returns data for the address seen one cycle earlier.
  always @(posedge clk) lag_addr <= raddr2;
  assign rdout2 = rom_byte(lag_addr);
  assign rok2   = 1'b1;

  typedef struct {
    bit            rst;
    bit            fix;
    logic [AW-1:0] a0, a1;
    logic          cs;
    logic [AW-1:0] addr;
    logic          ok0, ok1;
    logic [7:0]    d0, d1;
    logic          busy;
  } vec_t;

  vec_t vt [21];

  function automatic vec_t mk(bit r, bit f, logic [AW-1:0] x0, logic [AW-1:0] x1, logic c,
                              logic [AW-1:0] ad, logic o0, logic o1, logic [7:0] y0,
                              logic [7:0] y1, logic b);
    vec_t v;
    v.rst = r; v.fix = f; v.a0 = x0; v.a1 = x1; v.cs = c; v.addr = ad;
    v.ok0 = o0; v.ok1 = o1; v.d0 = y0; v.d1 = y1; v.busy = b;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic cond(input int w);
    case (w)
      0:       return ok0;
      1:       return ok1;
      2:       return ok0 && ok1;
      3:       return cs;
      default: return !cs;
    endcase
  endfunction

  task automatic wait_for(input int w, input int budget, input string name);
    int n = 0;
    while (!cond(w) && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(cond(w)), 32'd1);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic       bad;
    int         n;
    logic [1:0] miss_act;
    int         fills [2];
    int         wcyc  [2];
    logic       cs_prev;

    rst_n = 1'b0; a0 = '0; a1 = '0;
    rst2_n = 1'b0; b0 = '0; b1 = '0;
    ok_ovr = 1'b1; ok_force = 1'b1; fix_en = 1'b1; fix_val = 8'h5A;
    rand_dly = 1'b0; fixed_dly = 4'd0;

    vt[0]  = mk(1, 1, 21'h100, 21'h0, 1, 21'h100, 0, 0, 8'h00, 8'h00, 1);
    vt[1]  = mk(0, 1, 21'h100, 21'h0, 1, 21'h100, 0, 0, 8'h00, 8'h00, 1);
    vt[2]  = mk(0, 1, 21'h100, 21'h0, 0, 21'h100, 1, 0, 8'h5A, 8'h00, 0);
    vt[3]  = mk(0, 1, 21'h100, 21'h0, 1, 21'h000, 1, 0, 8'h5A, 8'h00, 1);
    vt[4]  = mk(0, 1, 21'h100, 21'h0, 1, 21'h000, 1, 0, 8'h5A, 8'h00, 1);
    vt[5]  = mk(0, 1, 21'h100, 21'h0, 0, 21'h000, 1, 1, 8'h5A, 8'h5A, 0);
    vt[6]  = mk(1, 0, 21'h200, 21'h100200, 1, 21'h200, 0, 0, 8'h00, 8'h00, 1);
    vt[7]  = mk(0, 0, 21'h200, 21'h100200, 1, 21'h200, 0, 0, 8'h00, 8'h00, 1);
    vt[8]  = mk(0, 0, 21'h200, 21'h100200, 0, 21'h200, 1, 0, rom_byte(21'h200), 8'h00, 0);
    vt[9]  = mk(0, 0, 21'h200, 21'h100200, 1, 21'h100200, 1, 0, rom_byte(21'h200), 8'h00, 1);
    vt[10] = mk(0, 0, 21'h200, 21'h100200, 1, 21'h100200, 1, 0, rom_byte(21'h200), 8'h00, 1);
    vt[11] = mk(0, 0, 21'h200, 21'h100200, 0, 21'h100200, 1, 1, rom_byte(21'h200),
                rom_byte(21'h100200), 0);
    vt[12] = mk(0, 0, 21'h300, 21'h100200, 1, 21'h300, 0, 1, 8'h00, rom_byte(21'h100200), 1);
    vt[13] = mk(0, 0, 21'h300, 21'h100200, 1, 21'h300, 0, 1, 8'h00, rom_byte(21'h100200), 1);
    vt[14] = mk(0, 0, 21'h300, 21'h100200, 0, 21'h300, 1, 1, rom_byte(21'h300),
                rom_byte(21'h100200), 0);
    vt[15] = mk(0, 0, 21'h400, 21'h100400, 1, 21'h100400, 0, 0, 8'h00, 8'h00, 1);
    vt[16] = mk(0, 0, 21'h400, 21'h100400, 1, 21'h100400, 0, 0, 8'h00, 8'h00, 1);
    vt[17] = mk(0, 0, 21'h400, 21'h100400, 0, 21'h100400, 0, 1, 8'h00, rom_byte(21'h100400), 0);
    vt[18] = mk(0, 0, 21'h400, 21'h100400, 1, 21'h400, 0, 1, 8'h00, rom_byte(21'h100400), 1);
    vt[19] = mk(0, 0, 21'h400, 21'h100400, 1, 21'h400, 0, 1, 8'h00, rom_byte(21'h100400), 1);
    vt[20] = mk(0, 0, 21'h400, 21'h100400, 0, 21'h400, 1, 1, rom_byte(21'h400),
                rom_byte(21'h100400), 0);

    for (int i = 0; i < 21; i++) begin
      a0 = vt[i].a0;
      a1 = vt[i].a1;
      fix_en = vt[i].fix;
      if (vt[i].rst) begin
        reset_dut();
        chk($sformatf("v%0d_rst_cs", i), 32'(cs), 32'd0);
        chk($sformatf("v%0d_rst_addr", i), 32'(raddr), 32'd0);
        chk($sformatf("v%0d_rst_ok", i), 32'({ok0, ok1, busy}), 32'd0);
        chk($sformatf("v%0d_rst_data", i), 32'({d0, d1}), 32'd0);
      end
      tick();
      chk($sformatf("v%0d_cs", i), 32'(cs), 32'(vt[i].cs));
      chk($sformatf("v%0d_addr", i), 32'(raddr), 32'(vt[i].addr));
      chk($sformatf("v%0d_ok0", i), 32'(ok0), 32'(vt[i].ok0));
      chk($sformatf("v%0d_ok1", i), 32'(ok1), 32'(vt[i].ok1));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vt[i].busy));
      if (vt[i].ok0) chk($sformatf("v%0d_d0", i), 32'(d0), 32'(vt[i].d0));
      if (vt[i].ok1) chk($sformatf("v%0d_d1", i), 32'(d1), 32'(vt[i].d1));
    end

    // Address change mid-fetch: stale fill must not satisfy the new address.
    ok_ovr = 1'b0; fix_en = 1'b0; fixed_dly = 4'd0;
    a0 = 21'h10; a1 = 21'h100000;
    reset_dut();
    wait_for(2, 40, "t3_setup");
    fixed_dly = 4'd5;
    a1 = 21'h100010;
    wait_for(3, 5, "t3_issue");
    chk("t3_addr1", 32'(raddr), 32'h100010);
    tick();
    a1 = 21'h100011;
    bad = 1'b0;
    n = 0;
    while (cs && n < 30) begin
      tick();
      if (ok1) bad = 1'b1;
      n++;
    end
    chk("t3_fill_done", 32'(cs), 32'd0);
    chk("t3_stale_ok1", 32'(ok1), 32'd0);
    chk("t3_other_entry", 32'({ok0, d0}), 32'({1'b1, rom_byte(21'h10)}));
    wait_for(3, 5, "t3_refetch");
    chk("t3_addr2", 32'(raddr), 32'h100011);
    wait_for(1, 40, "t3_ok1");
    chk("t3_d1", 32'(d1), 32'(rom_byte(21'h100011)));
    chk("t3_no_glitch", 32'(bad), 32'd0);

    // ROM_OK stuck high with OKDLY=2 and a one-cycle-late data path.
    b0 = 21'h500; b1 = 21'h100500;
    tick();
    rst2_n = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk($sformatf("t4_ok0_e%0d", e), 32'(k0), 32'(e == 4));
      if (e == 1) chk("t4_busy", 32'(busy2), 32'd1);
    end
    chk("t4_d0", 32'(e0), 32'(rom_byte(21'h500)));
    for (int e = 1; e <= 4; e++) tick();
    chk("t4_ok1", 32'({k1, e1}), 32'({1'b1, rom_byte(21'h100500)}));
    b0 = 21'h501;
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk($sformatf("t4_sw_ok0_e%0d", e), 32'(k0), 32'(e == 4));
    end
    chk("t4_sw_d0", 32'(e0), 32'(rom_byte(21'h501)));
    chk("t4_sw_cs", 32'(cs2), 32'd0);

    // Asynchronous reset in the middle of a WAIT.
    fixed_dly = 4'd8;
    a0 = 21'h20; a1 = 21'h100020;
    reset_dut();
    wait_for(2, 80, "t5_setup");
    a0 = 21'h600;
    wait_for(3, 5, "t5_issue");
    tick();
    rst_n = 1'b0;
    #1;
    chk("t5_async", 32'({cs, ok0, ok1, busy}), 32'd0);
    tick();
    rst_n = 1'b1;
    wait_for(3, 5, "t5_restart");
    chk("t5_addr", 32'(raddr), 32'h600);
    wait_for(0, 40, "t5_ok0");
    chk("t5_d0", 32'(d0), 32'(rom_byte(21'h600)));

    // Random address streams with random ROM latency.
    rand_dly = 1'b1;
    a0 = {$urandom_range(0, 1) ? 5'h10 : 5'h00, 12'h0, 4'($urandom_range(0, 15))};
    a1 = {$urandom_range(0, 1) ? 5'h10 : 5'h00, 12'h0, 4'($urandom_range(0, 15))};
    reset_dut();
    miss_act = 2'b11;
    fills[0] = 0; fills[1] = 0; wcyc[0] = 0; wcyc[1] = 0;
    cs_prev = cs;
    for (int c = 0; c < 4000; c++) begin
      tick();
      for (int r = 0; r < 2; r++) begin
        logic          okr;
        logic [7:0]    dr;
        logic [AW-1:0] ar;
        okr = (r == 0) ? ok0 : ok1;
        dr  = (r == 0) ? d0 : d1;
        ar  = (r == 0) ? a0 : a1;
        if (cs_prev && !cs && miss_act[r]) fills[r]++;
        if (okr) chk($sformatf("r%0d_data", r), 32'(dr), 32'(rom_byte(ar)));
        if (miss_act[r]) begin
          wcyc[r]++;
          if (okr) begin
            chk($sformatf("r%0d_starve", r), 32'(fills[r] <= 2), 32'd1);
            miss_act[r] = 1'b0;
          end else if (wcyc[r] > 150) begin
            chk($sformatf("r%0d_timeout", r), 32'(okr), 32'd1);
            miss_act[r] = 1'b0;
          end
        end
        if (okr && $urandom_range(0, 3) == 0) begin
          ar = {$urandom_range(0, 1) ? 5'h10 : 5'h00, 12'h0, 4'($urandom_range(0, 15))};
          if (r == 0) a0 = ar; else a1 = ar;
          miss_act[r] = 1'b1;
          fills[r] = 0;
          wcyc[r] = 0;
        end
      end
      cs_prev = cs;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
